// File: rtl/atm_controller_param_if.sv
// rtl/atm_controller_param_if.sv - Session/transaction bus of the ATM controller
//
// Groups every non-clock, non-reset signal of atm_controller_param.
//   master : drives card/PIN/amount/day inputs, observes results (bench, host)
//   slave  : the controller itself
// Parameters AMOUNT_W / BALANCE_W must match the controller instance.
interface atm_controller_param_if #(
  parameter int AMOUNT_W  = 32,
  parameter int BALANCE_W = 64
);
  logic                 tarjeta_recibida;
  logic                 cancelar;
  logic                 digito_stb;
  logic [3:0]           digito;
  logic                 tipo_trans;
  logic                 monto_stb;
  logic [AMOUNT_W-1:0]  monto;
  logic                 nuevo_dia;
  logic [BALANCE_W-1:0] balance;
  logic                 balance_actualizado;
  logic                 entregar_dinero;
  logic                 pin_incorrecto;
  logic                 advertencia;
  logic                 bloqueo;
  logic                 fondos_insuficientes;
  logic                 limite_excedido;

  modport master (
    output tarjeta_recibida, cancelar, digito_stb, digito, tipo_trans,
           monto_stb, monto, nuevo_dia,
    input  balance, balance_actualizado, entregar_dinero, pin_incorrecto,
           advertencia, bloqueo, fondos_insuficientes, limite_excedido
  );

  modport slave (
    input  tarjeta_recibida, cancelar, digito_stb, digito, tipo_trans,
           monto_stb, monto, nuevo_dia,
    output balance, balance_actualizado, entregar_dinero, pin_incorrecto,
           advertencia, bloqueo, fondos_insuficientes, limite_excedido
  );
endinterface

// File: rtl/atm_controller_param.sv
// rtl/atm_controller_param.sv - Parametrised ATM PIN/transaction controller
//
// Authenticates a PIN of PIN_DIGITS BCD digits (MSD first), locks after
// MAX_ATTEMPTS consecutive wrong PINs, then runs one deposit (saturating)
// or withdrawal against an internal balance register.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - atm_controller_param_if.slave
//          in : tarjeta_recibida, cancelar, digito_stb, digito, tipo_trans,
//               monto_stb, monto, nuevo_dia
//          out: balance, balance_actualizado, entregar_dinero, pin_incorrecto,
//               advertencia, bloqueo, fondos_insuficientes, limite_excedido
//
// Optional feature macro: ATM_DAILY_LIMIT_EN
//   defined   - daily withdrawal accumulator, nuevo_dia and limite_excedido
//   undefined - withdrawals limited by balance only, limite_excedido = 0
module atm_controller_param #(
  parameter int                        PIN_DIGITS   = 4,
  parameter logic [PIN_DIGITS*4-1:0]   PIN_VALUE    = 16'h1234,
  parameter int                        MAX_ATTEMPTS = 3,
  parameter int                        AMOUNT_W     = 32,
  parameter int                        BALANCE_W    = 64,
  parameter logic [BALANCE_W-1:0]      INIT_BALANCE = '0,
  parameter longint unsigned           DAILY_LIMIT  = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  atm_controller_param_if.slave bus
);

  localparam int PIN_W = PIN_DIGITS * 4;
  localparam int CNT_W = 4;
  localparam int ATT_W = 4;

  localparam logic [CNT_W-1:0]     DIGITS_C = CNT_W'(PIN_DIGITS);
  localparam logic [ATT_W-1:0]     ATT_LOCK = ATT_W'(MAX_ATTEMPTS);
  localparam logic [ATT_W-1:0]     ATT_WARN = ATT_W'(MAX_ATTEMPTS - 1);
  localparam logic [BALANCE_W-1:0] BAL_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_PIN, S_VERIFY, S_AMOUNT, S_EXEC, S_LOCK
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PIN_W-1:0]     pin_q, pin_d;
  logic [ATT_W-1:0]     att_q, att_d;
  logic                 adv_q, adv_d;
  logic                 blo_q, blo_d;
  logic [BALANCE_W-1:0] bal_q, bal_d;
  logic [AMOUNT_W-1:0]  monto_q, monto_d;
  logic                 tipo_q, tipo_d;
  logic                 upd_q, upd_d;
  logic                 ent_q, ent_d;
  logic                 inc_q, inc_d;
  logic                 fond_q, fond_d;

  logic [BALANCE_W-1:0] monto_ext;
  logic [BALANCE_W:0]   dep_sum;

  assign monto_ext = BALANCE_W'(monto_q);
  // One extra bit catches the carry used for saturation.
  assign dep_sum   = {1'b0, bal_q} + {1'b0, monto_ext};

`ifdef ATM_DAILY_LIMIT_EN
  localparam logic [BALANCE_W:0] LIMIT_EXT = (BALANCE_W+1)'(DAILY_LIMIT);

  logic [BALANCE_W-1:0] acc_q, acc_d;
  logic                 lim_q, lim_d;
  logic [BALANCE_W:0]   acc_sum;
  logic                 over_limit;

  assign acc_sum    = {1'b0, acc_q} + {1'b0, monto_ext};
  assign over_limit = acc_sum > LIMIT_EXT;
  assign bus.limite_excedido = lim_q;
`else
  localparam longint unsigned UNUSED_DAILY_LIMIT = DAILY_LIMIT;
  logic unused_nuevo_dia;
  assign unused_nuevo_dia    = bus.nuevo_dia;
  assign bus.limite_excedido = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    att_d   = att_q;
    adv_d   = adv_q;
    blo_d   = blo_q;
    bal_d   = bal_q;
    monto_d = monto_q;
    tipo_d  = tipo_q;
    upd_d   = 1'b0;
    ent_d   = 1'b0;
    inc_d   = 1'b0;
    fond_d  = 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
    lim_d   = 1'b0;
    acc_d   = acc_q;
    if (bus.nuevo_dia && state_q != S_LOCK) acc_d = '0;
`endif

    case (state_q)
      S_IDLE: begin
        // Keep the digit path cleared while idle so PIN always starts fresh.
        cnt_d = '0;
        pin_d = '0;
        if (bus.tarjeta_recibida) state_d = S_PIN;
      end

      S_PIN: begin
        if (bus.cancelar) begin
          state_d = S_IDLE;
        end else if (bus.digito_stb) begin
          pin_d = (pin_q << 4) | PIN_W'(bus.digito);
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == DIGITS_C) state_d = S_VERIFY;
        end
      end

      S_VERIFY: begin
        if (bus.cancelar) begin
          state_d = S_IDLE;
        end else if (pin_q == PIN_VALUE) begin
          att_d   = '0;
          adv_d   = 1'b0;
          state_d = S_AMOUNT;
        end else begin
          inc_d = 1'b1;
          att_d = att_q + 4'd1;
          cnt_d = '0;
          pin_d = '0;
          if (att_q + 4'd1 == ATT_LOCK) begin
            blo_d   = 1'b1;
            adv_d   = 1'b0;
            state_d = S_LOCK;
          end else begin
            if (att_q + 4'd1 == ATT_WARN) adv_d = 1'b1;
            state_d = S_PIN;
          end
        end
      end

      S_AMOUNT: begin
        if (bus.cancelar) begin
          state_d = S_IDLE;
        end else if (bus.monto_stb) begin
          monto_d = bus.monto;
          tipo_d  = bus.tipo_trans;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_IDLE;
        if (!tipo_q) begin
          bal_d = dep_sum[BALANCE_W] ? BAL_MAX : dep_sum[BALANCE_W-1:0];
          upd_d = 1'b1;
        end else if (monto_ext > bal_q) begin
          fond_d = 1'b1;
`ifdef ATM_DAILY_LIMIT_EN
        end else if (over_limit) begin
          lim_d = 1'b1;
`endif
        end else begin
          bal_d = bal_q - monto_ext;
          upd_d = 1'b1;
          ent_d = 1'b1;
`ifdef ATM_DAILY_LIMIT_EN
          // A coinciding new-day pulse wins: the limit was checked on old acc.
          acc_d = bus.nuevo_dia ? '0 : acc_sum[BALANCE_W-1:0];
`endif
        end
      end

      S_LOCK: begin
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pin_q   <= '0;
      att_q   <= '0;
      adv_q   <= 1'b0;
      blo_q   <= 1'b0;
      bal_q   <= INIT_BALANCE;
      monto_q <= '0;
      tipo_q  <= 1'b0;
      upd_q   <= 1'b0;
      ent_q   <= 1'b0;
      inc_q   <= 1'b0;
      fond_q  <= 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
      acc_q   <= '0;
      lim_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      att_q   <= att_d;
      adv_q   <= adv_d;
      blo_q   <= blo_d;
      bal_q   <= bal_d;
      monto_q <= monto_d;
      tipo_q  <= tipo_d;
      upd_q   <= upd_d;
      ent_q   <= ent_d;
      inc_q   <= inc_d;
      fond_q  <= fond_d;
`ifdef ATM_DAILY_LIMIT_EN
      acc_q   <= acc_d;
      lim_q   <= lim_d;
`endif
    end
  end

  assign bus.balance              = bal_q;
  assign bus.balance_actualizado  = upd_q;
  assign bus.entregar_dinero      = ent_q;
  assign bus.pin_incorrecto       = inc_q;
  assign bus.advertencia          = adv_q;
  assign bus.bloqueo              = blo_q;
  assign bus.fondos_insuficientes = fond_q;

endmodule

// File: tb/tb_atm_controller_param.sv
// tb/tb_atm_controller_param.sv - Scoreboard bench for atm_controller_param
`timescale 1ns/1ps
module tb_atm_controller_param;

  localparam int              MAXA  = 3;
  localparam longint unsigned LIMIT = 1000;
`ifdef ATM_DAILY_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  atm_controller_param_if #(.AMOUNT_W(32), .BALANCE_W(64)) bus_a ();
  atm_controller_param_if #(.AMOUNT_W(8),  .BALANCE_W(8))  bus_b ();

  atm_controller_param #(
    .PIN_DIGITS(4), .PIN_VALUE(16'h1234), .MAX_ATTEMPTS(MAXA),
    .AMOUNT_W(32), .BALANCE_W(64), .INIT_BALANCE(64'd0), .DAILY_LIMIT(LIMIT)
  ) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

  atm_controller_param #(
    .PIN_DIGITS(4), .PIN_VALUE(16'h1234), .MAX_ATTEMPTS(MAXA),
    .AMOUNT_W(8), .BALANCE_W(8), .INIT_BALANCE(8'd250), .DAILY_LIMIT(LIMIT)
  ) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit          inc, adv, blo, upd, ent, fond, lim;
    logic [63:0] bal;
    int          cyc;
  } ev_t;

  ev_t         q[$];
  logic [7:0]  qb[$];

  // Reference model state
  logic [63:0] m_bal;
  logic [63:0] m_acc;
  int          m_att;
  bit          m_adv, m_blo;

  // Monitor A: every output pulse must match the oldest expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst_a && (bus_a.pin_incorrecto || bus_a.balance_actualizado || bus_a.entregar_dinero ||
                  bus_a.fondos_insuficientes || bus_a.limite_excedido)) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse at cycle %0d actual=pulse required=none", cyc);
      end else begin
        e = q.pop_front();
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        chk("pin_incorrecto", {63'd0, bus_a.pin_incorrecto}, {63'd0, e.inc});
        chk("advertencia", {63'd0, bus_a.advertencia}, {63'd0, e.adv});
        chk("bloqueo", {63'd0, bus_a.bloqueo}, {63'd0, e.blo});
        chk("balance_actualizado", {63'd0, bus_a.balance_actualizado}, {63'd0, e.upd});
        chk("entregar_dinero", {63'd0, bus_a.entregar_dinero}, {63'd0, e.ent});
        chk("fondos_insuficientes", {63'd0, bus_a.fondos_insuficientes}, {63'd0, e.fond});
        chk("limite_excedido", {63'd0, bus_a.limite_excedido}, {63'd0, e.lim});
        chk("balance", bus_a.balance, e.bal);
      end
    end
  end

  // Monitor B: saturation instance.
  always @(negedge clk) begin
    logic [7:0] eb;
    if (rst_b && (bus_b.pin_incorrecto || bus_b.balance_actualizado || bus_b.entregar_dinero ||
                  bus_b.fondos_insuficientes || bus_b.limite_excedido)) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_pulse actual=pulse required=none");
      end else begin
        eb = qb.pop_front();
        chk("b_balance_actualizado", {63'd0, bus_b.balance_actualizado}, 64'd1);
        chk("b_sat_balance", {56'd0, bus_b.balance}, {56'd0, eb});
      end
    end
  end

  function automatic logic [15:0] wrong_pin();
    logic [15:0] p;
    for (int i = 0; i < 4; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
    if (p == 16'h1234) p = 16'h1111;
    return p;
  endfunction

  task automatic idle_a();
    bus_a.tarjeta_recibida = 0; bus_a.cancelar = 0; bus_a.digito_stb = 0; bus_a.digito = 0;
    bus_a.tipo_trans = 0; bus_a.monto_stb = 0; bus_a.monto = 0; bus_a.nuevo_dia = 0;
  endtask

  task automatic enter_pin(input logic [15:0] pin, input int cancel_idx, output bit cancelled);
    cancelled = 0;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      bus_a.digito     = pin[15-4*i -: 4];
      bus_a.digito_stb = 1;
      if (i == cancel_idx) bus_a.cancelar = 1;
      @(negedge clk);
      bus_a.digito_stb = 0;
      bus_a.cancelar   = 0;
      if (i == cancel_idx) begin
        cancelled = 1;
        return;
      end
    end
  endtask

  task automatic new_day();
    bus_a.nuevo_dia = 1;
    @(negedge clk);
    bus_a.nuevo_dia = 0;
    m_acc = 0;
  endtask

  // One card session; all expectations come from the model rules.
  task automatic session(input logic [15:0] pin, input int cancel_pin, input bit cancel_amt,
                         input bit wd, input logic [31:0] amt, input bit day_in_exec,
                         input bit card_in_exec);
    bit          c;
    ev_t         e;
    logic [64:0] sum;
    bus_a.tarjeta_recibida = 1;
    @(negedge clk);
    bus_a.tarjeta_recibida = 0;
    enter_pin(pin, cancel_pin, c);
    if (c) begin
      repeat (2) @(negedge clk);
      return;
    end
    e = '{inc: 0, adv: 0, blo: 0, upd: 0, ent: 0, fond: 0, lim: 0, bal: 0, cyc: 0};
    if (m_blo) begin
      bus_a.monto = amt; bus_a.tipo_trans = wd; bus_a.monto_stb = 1;
      @(negedge clk);
      bus_a.monto_stb = 0;
      repeat (3) @(negedge clk);
      return;
    end
    if (pin != 16'h1234) begin
      m_att++;
      if (m_att == MAXA) begin
        m_blo = 1; m_adv = 0;
      end else if (m_att == MAXA - 1) begin
        m_adv = 1;
      end
      e.inc = 1; e.adv = m_adv; e.blo = m_blo; e.bal = m_bal; e.cyc = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      if (!m_blo) begin
        bus_a.cancelar = 1;
        @(negedge clk);
        bus_a.cancelar = 0;
      end
      @(negedge clk);
      return;
    end
    m_att = 0;
    m_adv = 0;
    @(negedge clk);
    bus_a.monto = amt; bus_a.tipo_trans = wd; bus_a.monto_stb = 1; bus_a.cancelar = cancel_amt;
    @(negedge clk);
    bus_a.monto_stb = 0;
    bus_a.cancelar  = 0;
    if (cancel_amt) begin
      repeat (2) @(negedge clk);
      return;
    end
    if (!wd) begin
      sum   = {1'b0, m_bal} + {33'd0, amt};
      m_bal = sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sum[63:0];
      e.upd = 1;
    end else if (64'(amt) > m_bal) begin
      e.fond = 1;
    end else if (LIMIT_ON && (m_acc + 64'(amt) > LIMIT)) begin
      e.lim = 1;
    end else begin
      m_bal = m_bal - 64'(amt);
      m_acc = m_acc + 64'(amt);
      e.upd = 1; e.ent = 1;
    end
    e.adv = m_adv; e.blo = m_blo; e.bal = m_bal; e.cyc = cyc + 1;
    q.push_back(e);
    bus_a.nuevo_dia        = day_in_exec;
    bus_a.tarjeta_recibida = card_in_exec;
    @(negedge clk);
    bus_a.nuevo_dia        = 0;
    bus_a.tarjeta_recibida = 0;
    if (day_in_exec) m_acc = 0;
    @(negedge clk);
    if (card_in_exec) begin
      // If that card had been accepted these digits would yield a PIN event.
      for (int i = 0; i < 4; i++) begin
        bus_a.digito = 4'd1; bus_a.digito_stb = 1;
        @(negedge clk);
        bus_a.digito_stb = 0;
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic b_card_pin();
    bus_b.tarjeta_recibida = 1;
    @(negedge clk);
    bus_b.tarjeta_recibida = 0;
    for (int i = 0; i < 4; i++) begin
      bus_b.digito = 4'(i + 1); bus_b.digito_stb = 1;
      @(negedge clk);
      bus_b.digito_stb = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    bit          wd;
    logic [31:0] amt;
    idle_a();
    bus_b.tarjeta_recibida = 0; bus_b.cancelar = 0; bus_b.digito_stb = 0; bus_b.digito = 0;
    bus_b.tipo_trans = 0; bus_b.monto_stb = 0; bus_b.monto = 0; bus_b.nuevo_dia = 0;
    rst_a = 0; rst_b = 0;
    m_bal = 0; m_acc = 0; m_att = 0; m_adv = 0; m_blo = 0;
    repeat (3) @(negedge clk);
    chk("reset_balance", bus_a.balance, 64'd0);
    chk("reset_pulses", {59'd0, bus_a.pin_incorrecto, bus_a.balance_actualizado, bus_a.entregar_dinero,
                         bus_a.fondos_insuficientes, bus_a.limite_excedido}, 64'd0);
    chk("reset_levels", {62'd0, bus_a.advertencia, bus_a.bloqueo}, 64'd0);
    chk("reset_b_balance", {56'd0, bus_b.balance}, 64'd250);
    rst_a = 1; rst_b = 1;
    @(negedge clk);

    session(16'h1234, -1, 0, 0, 500, 0, 0);
    session(16'h1234, -1, 0, 1, 200, 0, 0);
    session(16'h1234, -1, 0, 1, 301, 0, 0);
    session(16'h1111, -1, 0, 0, 0, 0, 0);
    session(16'h1111, -1, 0, 0, 0, 0, 0);
    session(16'h1234, -1, 1, 0, 77, 0, 0);
    session(16'h1234, -1, 0, 0, 4700, 0, 1);
    session(16'h1234, -1, 0, 1, 800, 0, 0);
    session(16'h1234, -1, 0, 1, 300, 0, 0);
    new_day();
    session(16'h1234, -1, 0, 1, 300, 0, 0);
    session(16'h1234, 1, 0, 0, 5, 0, 0);
    session(16'h1234, -1, 0, 1, 0, 0, 0);
    session(16'h1234, -1, 0, 1, 600, 1, 0);
    session(16'h1234, -1, 0, 1, 900, 0, 0);

    for (int n = 0; n < 40; n++) begin
      wd  = 1'($urandom_range(0, 1));
      amt = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1500));
      if ($urandom_range(0, 7) == 0) new_day();
      session(($urandom_range(0, 7) == 0) ? wrong_pin() : 16'h1234,
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
              ($urandom_range(0, 9) == 0), wd, amt,
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    // Make sure the lock path is exercised from a clean attempt count.
    if (!m_blo) session(16'h1234, -1, 0, 0, 1, 0, 0);
    for (int n = 0; n < 5; n++) session(16'h1111, -1, 0, 0, 3, 0, 0);
    session(16'h1234, -1, 0, 0, 9, 0, 0);
    repeat (2) @(negedge clk);
    chk("lock_bloqueo", {63'd0, bus_a.bloqueo}, 64'd1);
    chk("lock_advertencia", {63'd0, bus_a.advertencia}, 64'd0);
    chk("lock_balance", bus_a.balance, m_bal);

    #2 rst_a = 0;
    #1;
    chk("async_rst_balance", bus_a.balance, 64'd0);
    chk("async_rst_levels", {62'd0, bus_a.advertencia, bus_a.bloqueo}, 64'd0);
    @(negedge clk);
    rst_a = 1;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    // Saturation instance: 250 + 10 clamps at 255, then reset in AMOUNT.
    b_card_pin();
    bus_b.monto = 8'd10; bus_b.tipo_trans = 0; bus_b.monto_stb = 1;
    @(negedge clk);
    bus_b.monto_stb = 0;
    qb.push_back(8'd255);
    repeat (3) @(negedge clk);
    chk("b_scoreboard_drained", 64'(qb.size()), 64'd0);
    b_card_pin();
    #2 rst_b = 0;
    #1;
    chk("b_async_rst_balance", {56'd0, bus_b.balance}, 64'd250);
    chk("b_async_rst_outputs", {57'd0, bus_b.pin_incorrecto, bus_b.balance_actualizado,
                                bus_b.entregar_dinero, bus_b.fondos_insuficientes,
                                bus_b.limite_excedido, bus_b.advertencia, bus_b.bloqueo}, 64'd0);
    @(negedge clk);
    rst_b = 1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
